load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one memory request at a time over a simple valid/ready bus,
// with lane steering, sign/zero extension, alignment checks and a bus-wait timeout.
module load_store_unit #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_address,
  output logic [3:0]  mem_wstrobe,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        done,
  output logic [31:0] load_data,
  output logic        error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  function automatic logic request_bad(input logic [2:0] f3, input logic st, input logic [1:0] off);
    logic bad;
    case (f3)
      3'b000:  bad = 1'b0;
      3'b001:  bad = off[0];
      3'b010:  bad = (off != 2'b00);
      3'b100:  bad = st;
      3'b101:  bad = st | off[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] s;
    case (f3[1:0])
      2'b00:   s = 4'b0001 << off;
      2'b01:   s = 4'b0011 << off;
      2'b10:   s = 4'b1111;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] d;
    case (f3[1:0])
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      2'b10:   d = wd;
      default: d = 32'h0000_0000;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] extract_load(input logic [31:0] rd, input logic [1:0] off,
                                               input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rd[{off, 3'b000} +: 8];
    h = off[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = rd;
      3'b100:  r = {24'h00_0000, b};
      3'b101:  r = {16'h0000, h};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  state_e      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        store_q, store_d;
  logic        mem_valid_q, mem_valid_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic [3:0]  mem_wstrobe_q, mem_wstrobe_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        done_q, done_d;
  logic [31:0] load_data_q, load_data_d;
  logic        error_q, error_d;

  // Next-state and registered-output computation
  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    off_d         = off_q;
    funct3_d      = funct3_q;
    store_d       = store_q;
    mem_valid_d   = mem_valid_q;
    mem_address_d = mem_address_q;
    mem_wstrobe_d = mem_wstrobe_q;
    mem_wdata_d   = mem_wdata_q;
    done_d        = done_q;
    load_data_d   = load_data_q;
    error_d       = error_q;
    case (state_q)
      IDLE: begin
        wait_d = 8'd0;
        if (req_valid) begin
          off_d    = req_address[1:0];
          funct3_d = req_funct3;
          store_d  = req_store;
          if (request_bad(req_funct3, req_store, req_address[1:0])) begin
            state_d     = DONE;
            done_d      = 1'b1;
            error_d     = 1'b1;
            load_data_d = 32'h0000_0000;
          end else begin
            state_d       = BUS;
            mem_valid_d   = 1'b1;
            mem_address_d = {req_address[31:2], 2'b00};
            mem_wstrobe_d = req_store ? store_strobe(req_funct3, req_address[1:0]) : 4'b0000;
            mem_wdata_d   = req_store ? store_data(req_funct3, req_wdata) : 32'h0000_0000;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUS: begin
        // A response on the same edge the wait budget runs out still wins.
        if (mem_ready || (wait_q == LAST_WAIT)) begin
          state_d       = DONE;
          done_d        = 1'b1;
          error_d       = ~mem_ready;
          load_data_d   = (mem_ready && !store_q) ? extract_load(mem_rdata, off_q, funct3_q)
                                                  : 32'h0000_0000;
          wait_d        = 8'd0;
          mem_valid_d   = 1'b0;
          mem_address_d = 32'h0000_0000;
          mem_wstrobe_d = 4'b0000;
          mem_wdata_d   = 32'h0000_0000;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      DONE: begin
        done_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        done_d      = 1'b0;
        mem_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      wait_q        <= 8'd0;
      off_q         <= 2'b00;
      funct3_q      <= 3'b000;
      store_q       <= 1'b0;
      mem_valid_q   <= 1'b0;
      mem_address_q <= 32'h0000_0000;
      mem_wstrobe_q <= 4'b0000;
      mem_wdata_q   <= 32'h0000_0000;
      done_q        <= 1'b0;
      load_data_q   <= 32'h0000_0000;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      off_q         <= off_d;
      funct3_q      <= funct3_d;
      store_q       <= store_d;
      mem_valid_q   <= mem_valid_d;
      mem_address_q <= mem_address_d;
      mem_wstrobe_q <= mem_wstrobe_d;
      mem_wdata_q   <= mem_wdata_d;
      done_q        <= done_d;
      load_data_q   <= load_data_d;
      error_q       <= error_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign mem_valid   = mem_valid_q;
  assign mem_address = mem_address_q;
  assign mem_wstrobe = mem_wstrobe_q;
  assign mem_wdata   = mem_wdata_q;
  assign done        = done_q;
  assign load_data   = load_data_q;
  assign error       = error_q;

endmodule
